// File: rtl/instruction_loader.sv
// instruction_loader
// Writer side of the instruction memory. Collects a byte stream over a
// valid/ready handshake, packs every four bytes little-endian into a 32-bit
// word and issues one write strobe per word at sequential byte addresses
// (word index = address >> 2). CPU fetch stays gated off until the whole
// program image has been written.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   start, num_words         load request and its word count (latched on accept)
//   byte_in, byte_valid      stream source
//   byte_ready               loader takes byte_in this cycle when byte_valid is high
//   mem_wr_en/addr/data      one-cycle write port to instruction memory
//   busy, done, error        load status; error is sticky until the next accepted start
//   fetch_enable             high only once a complete image is in memory
module instruction_loader #(
  parameter int DEPTH     = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        fetch_enable
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_e;

  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);
  localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);

  state_e      state_q, state_d;
  logic [7:0]  num_words_q, num_words_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic        error_q, error_d;

  logic        byte_ready_q, byte_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fetch_q, fetch_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        start_legal_s;
  logic        transfer_s;

  assign start_legal_s = (num_words != 8'd0) && ({1'b0, num_words} <= DEPTH_W);
  // byte_ready_q is high exactly while in LOAD, so this is the accepted-byte strobe
  assign transfer_s    = byte_valid & byte_ready_q;

  // Next-state and datapath update for the load sequence
  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (start_legal_s) begin
            state_d     = S_LOAD;
            num_words_d = num_words;
            word_idx_d  = 8'd0;
            byte_idx_d  = 2'd0;
            error_d     = 1'b0;
          end else begin
            // DONE keeps done/fetch_enable asserted on a rejected start
            error_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (transfer_s) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
          // 2-bit counter wraps to 0 after the fourth byte
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 8'd1;
        if (word_idx_d == num_words_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values derived from the upcoming state so every output is a flop
  always_comb begin
    byte_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    fetch_d      = (state_d == S_DONE);
    wr_en_d      = (state_d == S_WRITE);
    if (wr_en_d) begin
      wr_addr_d = BASE_W + {22'd0, word_idx_d, 2'b00};
      wr_data_d = word_d;
    end else begin
      wr_addr_d = 32'd0;
      wr_data_d = 32'd0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      num_words_q  <= 8'd0;
      word_idx_q   <= 8'd0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      error_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fetch_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      num_words_q  <= num_words_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      error_q      <= error_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fetch_q      <= fetch_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fetch_enable = fetch_q;
  assign error        = error_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;

endmodule
